// File: rtl/router_pkg.sv
// router_pkg: shared state encoding and default sizing for the router ingress controller.
package router_pkg;
   localparam int NUM_CH_DEF = 3;
   localparam int ADDR_W = 2;
   localparam int SOFT_RST_CYCLES_DEF = 30;
   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      LOAD_PARITY,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      WAIT_TILL_EMPTY,
      CHECK_PARITY_ERROR
   } state_t;
endpackage

// File: rtl/router_soft_rst_timer.sv
// router_soft_rst_timer: per-channel read timeout, pulses soft_reset when valid data sits unread too long.
module router_soft_rst_timer
   import router_pkg::*;
#(
   parameter int CYCLES = SOFT_RST_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic vld,
   input  logic read_enb,
   output logic soft_reset
);
   localparam int CW = $clog2(CYCLES);
   logic [CW-1:0] cnt;
   logic term;
   assign term = cnt == CW'(CYCLES - 1);
   // a read on the terminal cycle wins over the timeout
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         soft_reset <= 1'b0;
      end else begin
         soft_reset <= vld && !read_enb && term;
         cnt <= (!vld || read_enb || term) ? '0 : cnt + 1'b1;
      end
endmodule

// File: rtl/router_ctrl.sv
// router_ctrl: ingress FSM for the 1x3 router; sequences header/payload/parity,
// latches the destination and steers FIFO writes, with per-channel read timeouts.
module router_ctrl
   import router_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int SOFT_RST_CYCLES = SOFT_RST_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   input  logic [ADDR_W-1:0] data_in,
   input  logic [NUM_CH-1:0] fifo_full,
   input  logic [NUM_CH-1:0] fifo_empty,
   input  logic [NUM_CH-1:0] read_enb,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              rst_int_reg,
   output logic              write_enb_reg,
   output logic [NUM_CH-1:0] write_enb,
   output logic              fifo_full_sel,
   output logic              busy,
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset
);
   localparam int EXT_W = 1 << ADDR_W;
   state_t state, next;
   logic [ADDR_W-1:0] addr_q;
   logic [EXT_W-1:0] empty_x, full_x, srst_x;
   logic addr_ok;
   // widen per-channel vectors so any address value indexes in range
   assign empty_x = EXT_W'(fifo_empty);
   assign full_x = EXT_W'(fifo_full);
   assign srst_x = EXT_W'(soft_reset);
   assign addr_ok = int'(data_in) < NUM_CH;
   assign fifo_full_sel = full_x[addr_q];
   assign vld_out = ~fifo_empty;
   assign detect_add = state == DECODE_ADDRESS;
   assign lfd_state = state == LOAD_FIRST_DATA;
   assign ld_state = state == LOAD_DATA;
   assign laf_state = state == LOAD_AFTER_FULL;
   assign full_state = state == FIFO_FULL_STATE;
   assign rst_int_reg = state == CHECK_PARITY_ERROR;
   assign write_enb_reg = ld_state || laf_state || state == LOAD_PARITY;
   assign write_enb = write_enb_reg ? NUM_CH'(1) << addr_q : '0;
   assign busy = !(detect_add || ld_state);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= DECODE_ADDRESS;
         addr_q <= '0;
      end else begin
         state <= next;
         if (detect_add && pkt_valid && addr_ok) addr_q <= data_in;
      end
   always_comb begin
      next = state;
      case (state)
         DECODE_ADDRESS:
            if (pkt_valid && addr_ok) next = empty_x[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         WAIT_TILL_EMPTY:
            next = empty_x[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         LOAD_FIRST_DATA:
            next = LOAD_DATA;
         LOAD_DATA:
            next = fifo_full_sel ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
         FIFO_FULL_STATE:
            next = fifo_full_sel ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
         LOAD_AFTER_FULL:
            next = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
         LOAD_PARITY:
            next = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            next = fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
         default:
            next = DECODE_ADDRESS;
      endcase
      // a timeout on the active channel abandons the packet from any state
      if (!detect_add && srst_x[addr_q]) next = DECODE_ADDRESS;
   end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_tmr
      router_soft_rst_timer #(.CYCLES(SOFT_RST_CYCLES)) u_tmr (
         .clk(clk),
         .rst(rst),
         .vld(vld_out[i]),
         .read_enb(read_enb[i]),
         .soft_reset(soft_reset[i])
      );
   end
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed-vector bench for router_ctrl with hand-computed expectations.
module tb_router_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic pkt_valid;
   logic [1:0] data_in;
   logic [2:0] fifo_full, fifo_empty, read_enb;
   logic parity_done, low_pkt_valid;
   logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic write_enb_reg, fifo_full_sel, busy;
   logic [2:0] write_enb, vld_out, soft_reset;
   int checks = 0;
   int failures = 0;
   router_ctrl dut (
      .clk(clk),
      .rst(rst),
      .pkt_valid(pkt_valid),
      .data_in(data_in),
      .fifo_full(fifo_full),
      .fifo_empty(fifo_empty),
      .read_enb(read_enb),
      .parity_done(parity_done),
      .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add),
      .lfd_state(lfd_state),
      .ld_state(ld_state),
      .laf_state(laf_state),
      .full_state(full_state),
      .rst_int_reg(rst_int_reg),
      .write_enb_reg(write_enb_reg),
      .write_enb(write_enb),
      .fifo_full_sel(fifo_full_sel),
      .busy(busy),
      .vld_out(vld_out),
      .soft_reset(soft_reset)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1;
      pkt_valid = 1'b0;
      data_in = 2'd0;
      fifo_full = 3'b000;
      fifo_empty = 3'b111;
      read_enb = 3'b000;
      parity_done = 1'b0;
      low_pkt_valid = 1'b0;
      step();
      chk("rst_detect", detect_add, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", write_enb, 0);
      chk("rst_srst", soft_reset, 0);
      chk("rst_flags", {lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg}, 0);
      rst = 1'b0;
      // header to empty channel 1, then payload
      pkt_valid = 1'b1;
      data_in = 2'd1;
      step();
      chk("t1_lfd", lfd_state, 1);
      chk("t1_lfd_busy", busy, 1);
      chk("t1_lfd_we", write_enb, 0);
      step();
      chk("t1_ld", ld_state, 1);
      chk("t1_ld_we", write_enb, 3'b010);
      chk("t1_ld_busy", busy, 0);
      repeat (2) step();
      chk("t2_ld_stay", ld_state, 1);
      pkt_valid = 1'b0;
      step();
      chk("t2_par_we", write_enb, 3'b010);
      chk("t2_par_busy", busy, 1);
      chk("t2_par_ld", ld_state, 0);
      step();
      chk("t2_chk_rir", rst_int_reg, 1);
      chk("t2_chk_we", write_enb, 0);
      step();
      chk("t2_back_detect", detect_add, 1);
      chk("t2_back_rir", rst_int_reg, 0);
      // full stall mid-payload on channel 1
      pkt_valid = 1'b1;
      step();
      step();
      chk("t3_ld", ld_state, 1);
      fifo_full = 3'b010;
      step();
      chk("t3_full", full_state, 1);
      chk("t3_full_we", write_enb, 0);
      chk("t3_full_busy", busy, 1);
      chk("t3_full_sel", fifo_full_sel, 1);
      step();
      chk("t3_full_stay", full_state, 1);
      fifo_full = 3'b000;
      step();
      chk("t3_laf", laf_state, 1);
      chk("t3_laf_we", write_enb, 3'b010);
      low_pkt_valid = 1'b1;
      step();
      chk("t3_par", {ld_state, laf_state, write_enb_reg, busy}, 4'b0011);
      step();
      chk("t3_chk", rst_int_reg, 1);
      low_pkt_valid = 1'b0;
      step();
      chk("t3_detect", detect_add, 1);
      // channel 2 busy: wait until it drains
      fifo_empty = 3'b011;
      data_in = 2'd2;
      step();
      chk("t4_wait_busy", busy, 1);
      chk("t4_wait_lfd", lfd_state, 0);
      chk("t4_vld", vld_out, 3'b100);
      pkt_valid = 1'b0;
      repeat (4) step();
      chk("t4_wait_stay", {detect_add, lfd_state, busy}, 3'b001);
      fifo_empty = 3'b111;
      step();
      chk("t4_lfd", lfd_state, 1);
      step();
      chk("t4_ld_we", write_enb, 3'b100);
      repeat (3) step();
      chk("t4_detect", detect_add, 1);
      // invalid address 3 is dropped
      pkt_valid = 1'b1;
      data_in = 2'd3;
      step();
      chk("t4_bad_detect", detect_add, 1);
      chk("t4_bad_we", write_enb, 0);
      chk("t4_bad_lfd", lfd_state, 0);
      pkt_valid = 1'b0;
      // timeout: unread channel 0 fires after 30 cycles
      fifo_empty = 3'b110;
      repeat (29) step();
      chk("t5_pre", soft_reset, 0);
      step();
      chk("t5_pulse", soft_reset, 3'b001);
      step();
      chk("t5_once", soft_reset, 0);
      fifo_empty = 3'b111;
      step();
      fifo_empty = 3'b110;
      repeat (29) step();
      read_enb = 3'b001;
      step();
      chk("t5_suppr", soft_reset, 0);
      read_enb = 3'b000;
      step();
      chk("t5_suppr2", soft_reset, 0);
      fifo_empty = 3'b111;
      step();
      // timeout abort from WAIT_TILL_EMPTY
      fifo_empty = 3'b110;
      pkt_valid = 1'b1;
      data_in = 2'd0;
      step();
      pkt_valid = 1'b0;
      repeat (29) step();
      chk("t6_wait_srst", {soft_reset, busy, detect_add}, 5'b00110);
      step();
      chk("t6_wait_abort", detect_add, 1);
      fifo_empty = 3'b111;
      step();
      // timeout abort from LOAD_DATA
      pkt_valid = 1'b1;
      data_in = 2'd1;
      step();
      step();
      fifo_empty = 3'b101;
      repeat (30) step();
      chk("t6_ld_srst", {soft_reset, ld_state}, 4'b0101);
      step();
      chk("t6_ld_abort", {detect_add, write_enb}, 4'b1000);
      fifo_empty = 3'b111;
      step();
      // async reset mid-packet
      step();
      step();
      chk("t6_ld2", ld_state, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst", {detect_add, ld_state, busy, write_enb}, 6'b100000);
      step();
      rst = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
